// File: rtl/cmp_threshold_monitor.sv
// rtl/cmp_threshold_monitor.sv - debounced window monitor producing over/under-range alarms
module cmp_threshold_monitor #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic             cfg_load,
  output logic             cfg_err,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             in_band,
  output logic             event_valid,
  output logic [1:0]       event_code
);

  localparam logic [2:0] S_IN_BAND  = 3'd0;
  localparam logic [2:0] S_PEND_HI  = 3'd1;
  localparam logic [2:0] S_PEND_LO  = 3'd2;
  localparam logic [2:0] S_ALARM_HI = 3'd3;
  localparam logic [2:0] S_ALARM_LO = 3'd4;

  // Class codes double as the event codes for the matching alarm set.
  localparam logic [1:0] C_INSIDE = 2'b00;
  localparam logic [1:0] C_ABOVE  = 2'b01;
  localparam logic [1:0] C_BELOW  = 2'b10;
  localparam logic [1:0] EV_CLEAR = 2'b11;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [WIDTH-1:0] thr_hi, thr_lo;
  logic [1:0]       cls;
  logic             cls_valid;
  logic [2:0]       state, state_n;
  logic [3:0]       cnt, cnt_n, cnt_inc;
  logic [1:0]       ev_n;
  logic             load_ok;
  logic             same_dir;
  logic [2:0]       alarm_state;
  logic [2:0]       pend_state;

  assign load_ok = cfg_load && (cfg_lo <= cfg_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_hi  <= '1;
      thr_lo  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !load_ok;
      if (load_ok) begin
        thr_hi <= cfg_hi;
        thr_lo <= cfg_lo;
      end
    end
  end

  // Classification uses the thresholds in force before any same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls       <= C_INSIDE;
      cls_valid <= 1'b0;
    end else begin
      cls_valid <= sample_valid;
      if (sample_valid) begin
        if (sample > thr_hi)      cls <= C_ABOVE;
        else if (sample < thr_lo) cls <= C_BELOW;
        else                      cls <= C_INSIDE;
      end
    end
  end

  assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign same_dir    = (cls == C_ABOVE && state == S_PEND_HI) ||
                       (cls == C_BELOW && state == S_PEND_LO);
  assign alarm_state = (cls == C_ABOVE) ? S_ALARM_HI : S_ALARM_LO;
  assign pend_state  = (cls == C_ABOVE) ? S_PEND_HI : S_PEND_LO;

  // An accepted load takes precedence over the classified sample that cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ev_n    = 2'b00;
    if (load_ok) begin
      if (state == S_PEND_HI || state == S_PEND_LO) begin
        state_n = S_IN_BAND;
        cnt_n   = 4'd0;
      end
    end else if (cls_valid) begin
      case (state)
        S_IN_BAND, S_PEND_HI, S_PEND_LO: begin
          if (cls == C_INSIDE) begin
            state_n = S_IN_BAND;
            cnt_n   = 4'd0;
          end else if (same_dir) begin
            if (cnt_inc == DEB) begin
              state_n = alarm_state;
              cnt_n   = 4'd0;
              ev_n    = cls;
            end else begin
              cnt_n = cnt_inc;
            end
          end else if (DEB == 4'd1) begin
            state_n = alarm_state;
            cnt_n   = 4'd0;
            ev_n    = cls;
          end else begin
            state_n = pend_state;
            cnt_n   = 4'd1;
          end
        end
        S_ALARM_HI, S_ALARM_LO: begin
          if (cls == C_INSIDE) begin
            if (cnt_inc == DEB) begin
              state_n = S_IN_BAND;
              cnt_n   = 4'd0;
              ev_n    = EV_CLEAR;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = 4'd0;
          end
        end
        default: begin
          state_n = S_IN_BAND;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IN_BAND;
      cnt         <= 4'd0;
      event_valid <= 1'b0;
      event_code  <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      event_valid <= (ev_n != 2'b00);
      event_code  <= ev_n;
    end
  end

  assign alarm_hi = (state == S_ALARM_HI);
  assign alarm_lo = (state == S_ALARM_LO);
  assign in_band  = !(alarm_hi || alarm_lo);

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// tb/tb_cmp_threshold_monitor.sv - self-checking bench for cmp_threshold_monitor
module tb_cmp_threshold_monitor;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sample = 4'd0;
  logic       sample_valid = 1'b0;
  logic [3:0] cfg_hi = 4'd0;
  logic [3:0] cfg_lo = 4'd0;
  logic       cfg_load = 1'b0;
  logic       cfg_err, alarm_hi, alarm_lo, in_band, event_valid;
  logic [1:0] event_code;

  always #5 clk = ~clk;

  cmp_threshold_monitor #(.WIDTH(4), .DEBOUNCE(D)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_load(cfg_load), .cfg_err(cfg_err),
    .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .in_band(in_band),
    .event_valid(event_valid), .event_code(event_code)
  );

  int errs = 0;
  int checks = 0;
  int n_ev[4] = '{0, 0, 0, 0};

  // Reference: alarm 0=none 1=hi 2=lo; class 0=inside 1=above 2=below.
  int m_hi = 15, m_lo = 0;
  bit p_v = 0;
  int p_c = 0;
  int alarm = 0, run_dir = 0, run_len = 0, clr = 0;
  bit e_v = 0, e_err = 0;
  int e_c = 0;
  bit ok;

  function automatic int classify(input int s, input int h, input int l);
    if (s > h) return 1;
    if (s < l) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 15; m_lo = 0; p_v = 0; p_c = 0;
      alarm = 0; run_dir = 0; run_len = 0; clr = 0;
      e_v = 0; e_c = 0; e_err = 0;
    end else begin
      ok = cfg_load && (cfg_lo <= cfg_hi);
      e_v = 0; e_c = 0;
      if (ok) begin
        if (alarm == 0) begin run_dir = 0; run_len = 0; end
      end else if (p_v) begin
        if (alarm == 0) begin
          if (p_c == 0) begin
            run_dir = 0; run_len = 0;
          end else begin
            if (p_c == run_dir) run_len++;
            else begin run_dir = p_c; run_len = 1; end
            if (run_len >= D) begin
              alarm = p_c; e_v = 1; e_c = p_c;
              run_dir = 0; run_len = 0; clr = 0;
            end
          end
        end else begin
          if (p_c == 0) begin
            clr++;
            if (clr >= D) begin alarm = 0; clr = 0; e_v = 1; e_c = 3; end
          end else clr = 0;
        end
      end
      p_v = sample_valid;
      p_c = classify(int'(sample), m_hi, m_lo);
      e_err = cfg_load && !ok;
      if (ok) begin m_hi = int'(cfg_hi); m_lo = int'(cfg_lo); end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("alarm_hi", int'(alarm_hi), int'(alarm == 1));
      chk("alarm_lo", int'(alarm_lo), int'(alarm == 2));
      chk("in_band", int'(in_band), int'(alarm == 0));
      chk("event_valid", int'(event_valid), int'(e_v));
      chk("event_code", int'(event_code), e_c);
      chk("cfg_err", int'(cfg_err), int'(e_err));
      if (event_valid) n_ev[event_code]++;
    end
  end

  task automatic put(input int v);
    sample = 4'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int h, input int l);
    cfg_hi = 4'(h);
    cfg_lo = 4'(l);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  int snap;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("lit_rst_in_band", int'(in_band), 1);
    chk("lit_rst_alarm_hi", int'(alarm_hi), 0);
    chk("lit_rst_alarm_lo", int'(alarm_lo), 0);
    chk("lit_rst_event_valid", int'(event_valid), 0);
    chk("lit_rst_cfg_err", int'(cfg_err), 0);

    put(15); put(15); put(15); idle(2); #1;
    chk("lit_f_inside", int'(in_band), 1);

    load(10, 4);
    put(11); put(12); put(13); #1;
    chk("lit_hi_not_yet", int'(alarm_hi), 0);
    idle(1); #1;
    chk("lit_hi_set", int'(alarm_hi), 1);
    chk("lit_hi_event_cnt", n_ev[1], 1);
    put(7); put(7); put(7); idle(1); #1;
    chk("lit_hi_cleared", int'(in_band), 1);
    chk("lit_clear_cnt1", n_ev[3], 1);

    put(11); put(12); put(5); idle(2); #1;
    chk("lit_broken_run", int'(in_band), 1);
    chk("lit_broken_no_event", n_ev[1], 1);

    put(10); put(10); put(10); put(4); put(4); put(4); idle(2); #1;
    chk("lit_boundary_inside", int'(in_band), 1);

    put(3); idle(2); put(2); put(1); idle(1); #1;
    chk("lit_lo_set", int'(alarm_lo), 1);
    chk("lit_lo_event_cnt", n_ev[2], 1);
    put(7); put(15); put(7); put(7); idle(1); #1;
    chk("lit_lo_held", int'(alarm_lo), 1);
    chk("lit_no_hi_swap", int'(alarm_hi), 0);
    put(7); idle(1); #1;
    chk("lit_lo_cleared", int'(in_band), 1);
    chk("lit_clear_cnt2", n_ev[3], 2);

    load(3, 9); #1;
    chk("lit_cfg_err_pulse", int'(cfg_err), 1);
    @(negedge clk); #1;
    chk("lit_cfg_err_end", int'(cfg_err), 0);
    put(5); put(5); put(5); idle(1); #1;
    chk("lit_thr_kept_inside", int'(in_band), 1);
    put(11); put(11); put(11); idle(1); #1;
    chk("lit_thr_kept_above", int'(alarm_hi), 1);
    put(5); put(5); put(5); idle(1);

    put(11); put(11); load(12, 4); idle(1); #1;
    chk("lit_load_cancels_pend", int'(in_band), 1);
    put(13); put(13); idle(1); #1;
    chk("lit_fresh_count", int'(alarm_hi), 0);
    put(13); idle(1); #1;
    chk("lit_fresh_alarm", int'(alarm_hi), 1);

    snap = n_ev[0] + n_ev[1] + n_ev[2] + n_ev[3];
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_alarm_hi", int'(alarm_hi), 0);
    chk("lit_async_in_band", int'(in_band), 1);
    idle(2);
    rst_n = 1'b1;
    idle(3); #1;
    chk("lit_no_event_after_rst", n_ev[0] + n_ev[1] + n_ev[2] + n_ev[3], snap);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        sample_valid = ($urandom_range(0, 9) < 7);
        sample = 4'($urandom_range(0, 15));
        cfg_load = ($urandom_range(0, 19) == 0);
        cfg_lo = 4'($urandom_range(0, 7));
        cfg_hi = 4'($urandom_range(4, 15));
        @(negedge clk);
      end
    end
    sample_valid = 1'b0;
    cfg_load = 1'b0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
